// File: rtl/ddr_rx_deser.sv
// DDR receive deserializer: pairs of IO-cell samples feed a shift register, a
// SYNC word sets the bit alignment, and aligned words drain through a 2-deep FIFO.
//
// state    | meaning
// S_HUNT   | searching every candidate offset for SYNC, nothing is emitted
// S_LOCKED | alignment fixed, one word pushed every WORD_W/2 cycles
module ddr_rx_deser #(
   parameter int                WORD_W = 8,
   parameter logic [WORD_W-1:0] SYNC   = 8'hA5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      din0,
   input  logic                      din1,
   input  logic                      en,
   input  logic                      resync,
   output logic [WORD_W-1:0]         out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      locked,
   output logic [$clog2(WORD_W)-1:0] align_ofs,
   output logic                      overflow
);

   localparam int SR_W  = 2 * WORD_W;
   localparam int OFS_W = $clog2(WORD_W);
   localparam int PH_W  = $clog2(WORD_W / 2);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(WORD_W / 2 - 1);

   typedef enum logic {
      S_HUNT   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [SR_W-1:0]    r_sr;
   logic [SR_W-1:0]    w_sr_nxt;
   logic [PH_W-1:0]    r_phase;
   logic [OFS_W-1:0]   r_ofs;
   logic [OFS_W-1:0]   w_match_ofs;
   logic               w_match;
   logic               w_flush;
   logic               w_push;
   logic               w_pop;
   logic               w_acc;
   logic [WORD_W-1:0]  w_word;
   logic [WORD_W-1:0]  r_q0;
   logic [WORD_W-1:0]  r_q1;
   logic [1:0]         r_cnt;
   logic               r_ovf;

   // Matching and word capture both look at the register value after this edge's shift.
   always_comb begin
      w_sr_nxt    = en ? {r_sr[SR_W-3:0], din0, din1} : r_sr;
      w_match     = 1'b0;
      w_match_ofs = '0;
      for (int k = WORD_W - 1; k >= 0; k--) begin
         if (w_sr_nxt[k +: WORD_W] == SYNC) begin
            w_match     = 1'b1;
            w_match_ofs = OFS_W'(k);
         end
      end
      w_word = w_sr_nxt[r_ofs +: WORD_W];
   end

   always_comb begin
      w_flush     = !en || resync;
      w_state_nxt = r_state;
      w_push      = 1'b0;
      case (r_state)
         S_HUNT: begin
            if (w_match) w_state_nxt = S_LOCKED;
         end
         S_LOCKED: begin
            if (r_phase == PH_LAST) w_push = 1'b1;
         end
         default: w_state_nxt = S_HUNT;
      endcase
      if (w_flush) begin
         w_state_nxt = S_HUNT;
         w_push      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_HUNT;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sr    <= '0;
         r_phase <= '0;
         r_ofs   <= '0;
      end else begin
         r_sr <= w_sr_nxt;
         if (w_flush) begin
            r_phase <= '0;
         end else if (r_state == S_HUNT) begin
            r_phase <= '0;
            if (w_match) r_ofs <= w_match_ofs;
         end else begin
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
         end
      end
   end

   assign w_pop = (r_cnt != 2'd0) && out_ready;
   assign w_acc = w_push && ((r_cnt != 2'd2) || w_pop);

   // r_q0 is always the head, so out_data cannot move while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q0  <= '0;
         r_q1  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_flush) begin
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_pop) begin
         if (w_acc) begin
            if (r_cnt == 2'd1) begin
               r_q0 <= w_word;
            end else begin
               r_q0 <= r_q1;
               r_q1 <= w_word;
            end
         end else begin
            r_q0  <= r_q1;
            r_cnt <= r_cnt - 2'd1;
         end
      end else if (w_acc) begin
         if (r_cnt == 2'd0) r_q0 <= w_word;
         else               r_q1 <= w_word;
         r_cnt <= r_cnt + 2'd1;
      end else if (w_push) begin
         r_ovf <= 1'b1;
      end
   end

   assign out_data  = r_q0;
   assign out_valid = (r_cnt != 2'd0);
   assign locked    = (r_state == S_LOCKED);
   assign align_ofs = r_ofs;
   assign overflow  = r_ovf;

endmodule

// File: doc/ddr_rx_deser.md
DDR_RX_DESER -- requirements
Module: ddr_rx_deser

Interface
REQ-001 Parameter WORD_W, default 8, meaning: output word width in bits; SHALL be even and at least 4.
REQ-002 Parameter SYNC, default 8'hA5, meaning: WORD_W-bit alignment pattern searched for in the bit stream.
REQ-003 clk  input  1  single clock; also the IO cell INPUTCLK, with rising-edge capture.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 din0  input  1  IO-cell DIN0 (rising-edge sample); earlier bit in time.
REQ-006 din1  input  1  IO-cell DIN1 (falling-edge sample); later bit in time.
REQ-007 en  input  1  stream enable; low forces HUNT and flushes the output.
REQ-008 resync  input  1  one-cycle pulse that forces HUNT and flushes the output.
REQ-009 out_data  output  WORD_W  received word, MSB = earliest bit.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_ready  input  1  consumer accepts out_data.
REQ-012 locked  output  1  high in LOCKED state.
REQ-013 align_ofs  output  $clog2(WORD_W)  locked bit offset k.
REQ-014 overflow  output  1  sticky: a word was dropped.

Function
REQ-015 The block SHALL keep a 2*WORD_W-bit shift register updated every cycle while en=1: sr <= {sr[2W-3:0], din0, din1}. It SHALL hold when en=0.
REQ-016 The candidate word at offset k (k = 0..WORD_W-1) SHALL be sr[k+W-1:k].
REQ-017 The state machine SHALL have two states, HUNT and LOCKED, and SHALL reset to HUNT.
REQ-018 HUNT: each cycle, compare all candidates against SYNC using the sr value after that cycle's update.
  - On any match: go to LOCKED, set align_ofs to the lowest matching k, clear the phase counter to 0.
  - The sync word itself SHALL NOT be output.
REQ-019 LOCKED: the phase counter SHALL count 0..W/2-1 and wrap.
  - Each time it reaches W/2-1, candidate align_ofs SHALL be pushed into the output FIFO on the next edge.
  - First data word: completes W/2 cycles after the match and is visible on out_valid one cycle later.
REQ-020 LOCKED SHALL NOT re-search for SYNC; a SYNC value in data SHALL be output as ordinary data.
REQ-021 en=0 or resync=1 SHALL, on that edge:
  - go to HUNT, clear the phase counter, clear locked;
  - empty the FIFO (out_valid=0), clear overflow.
  - resync takes priority over a simultaneous match or push.
REQ-022 The output SHALL be a 2-entry FIFO.
  - Pop on out_valid & out_ready.
  - out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 A push into a full FIFO with a simultaneous pop SHALL be accepted.
REQ-024 A push into a full FIFO without a pop SHALL be dropped and set overflow=1; the FIFO contents SHALL be unchanged.
REQ-025 overflow SHALL remain 1 until reset, resync or en=0.
REQ-026 Output timing: locked rises the cycle after the matching edge. align_ofs SHALL hold its value while LOCKED.

Reset
REQ-027 With rst_n=0 at a clock edge, the block SHALL set:
  - sr=0, state=HUNT, phase=0;
  - locked=0, align_ofs=0, out_valid=0, out_data=0, overflow=0, FIFO empty.
REQ-028 Reset asserted mid-word or mid-transfer SHALL discard all partial and queued data.
  - After reset release, no word SHALL be output before a new SYNC match.
REQ-029 No behaviour SHALL depend on the asynchronous assertion of rst_n.

Verification (WORD_W=8, SYNC=A5, out_ready=1 unless stated)
REQ-030 Offset 0: stream zeros, then A5, 3C, 7E MSB-first, paired (din0,din1) per cycle.
  - Expect locked=1, align_ofs=0.
  - Expect out_data 3C then 7E, 4 cycles apart, each valid 1 cycle after its last bit; A5 never output.
REQ-031 Offset 3: prefix 3 extra bits (101) before A5, 3C, 7E.
  - Expect align_ofs per REQ-018 (lowest matching k).
  - Expect the same 3C, 7E output and no spurious word.
REQ-032 Backpressure: after lock, out_ready=0 and send 11, 22, 33, 44.
  - Expect FIFO to hold 11, 22 and overflow=1.
  - On out_ready=1, expect 11 then 22, then nothing; overflow stays 1.
REQ-033 Resync mid-stream: pulse resync while a word is half received and one word is queued.
  - Next cycle: locked=0, out_valid=0, overflow=0.
  - Re-lock only on the next A5.
REQ-034 Reset mid-operation: drive rst_n=0 for 1 cycle while LOCKED with FIFO full.
  - All outputs at reset values next cycle.
  - A subsequent 3C without SYNC produces no output.
REQ-035 en low: drop en for 5 cycles mid-stream, then resume.
  - Expect HUNT, no output, sr held.
  - Re-lock on the next A5.
